hilo_muldiv_unit: RTL and testbench

- Iterative multiply/divide engine with architectural HI/LO registers for the Execute stage.
- Executes MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO.
- Replaces the single-cycle HI/LO path: HiData/LoData feed the EX_MEM HI/LO inputs.
- Stall holds IF/ID/EX while an operation is in flight.

---
 rtl/hilo_muldiv_unit_if.sv | 25 ++
 rtl/hilo_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the Execute stage and the HI/LO multiply/divide engine.
interface hilo_muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Start;
   logic [2:0]            Op;
   logic [DATA_WIDTH-1:0] OperandA;
   logic [DATA_WIDTH-1:0] OperandB;
   logic                  Busy;
   logic                  Stall;
   logic                  Done;
   logic                  DivByZero;
   logic [DATA_WIDTH-1:0] HiData;
   logic [DATA_WIDTH-1:0] LoData;

   modport master (
      output Start, Op, OperandA, OperandB,
      input  Busy, Stall, Done, DivByZero, HiData, LoData
   );

   modport slave (
      input  Start, Op, OperandA, OperandB,
      output Busy, Stall, Done, DivByZero, HiData, LoData
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the architectural HI/LO registers.
module hilo_muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic              Clk,
   input logic              Rst,
   hilo_muldiv_unit_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FINAL} stateE;
   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MADD  = 3'b100,
      OP_MSUB  = 3'b101,
      OP_MTHI  = 3'b110,
      OP_MTLO  = 3'b111
   } opE;

   stateE          state, nextState;
   opE             opReg;
   logic [CW-1:0]  count;
   logic [2*W-1:0] work;
   logic [W-1:0]   operand;
   logic           negLo, negHi, dz;
   logic [W-1:0]   hiReg, loReg;
   logic           doneReg, dzReg;

   opE             opIn;
   logic           startIsMove, startIsDiv, startSigned, aNeg, bNeg, divZero;
   logic [W-1:0]   aAbs, bAbs;

   always_comb begin
      opIn        = opE'(bus.Op);
      startIsMove = (opIn == OP_MTHI) || (opIn == OP_MTLO);
      startIsDiv  = (opIn == OP_DIV) || (opIn == OP_DIVU);
      startSigned = (opIn == OP_MULT) || (opIn == OP_DIV) || (opIn == OP_MADD) || (opIn == OP_MSUB);
      aNeg        = startSigned && bus.OperandA[W-1];
      bNeg        = startSigned && bus.OperandB[W-1];
      aAbs        = aNeg ? -bus.OperandA : bus.OperandA;
      bAbs        = bNeg ? -bus.OperandB : bus.OperandB;
      divZero     = startIsDiv && (bus.OperandB == '0);
   end

   // Both algorithms share one 2W register: {acc, multiplier} or {remainder, quotient}.
   logic           isDiv;
   logic [W:0]     mulSum, divShift, divDiff;
   logic [2*W-1:0] mulStep, divStep;

   always_comb begin
      isDiv    = (opReg == OP_DIV) || (opReg == OP_DIVU);
      mulSum   = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, operand} : '0);
      mulStep  = {mulSum, work[W-1:1]};
      divShift = {work[2*W-1:W], work[W-1]};
      divDiff  = divShift - {1'b0, operand};
      divStep  = divDiff[W] ? {divShift[W-1:0], work[W-2:0], 1'b0}
                            : {divDiff[W-1:0], work[W-2:0], 1'b1};
   end

   logic [2*W-1:0] product, hiLo, result;
   logic [W-1:0]   quo, rem;

   always_comb begin
      product = negLo ? -work : work;
      quo     = negLo ? -work[W-1:0] : work[W-1:0];
      rem     = negHi ? -work[2*W-1:W] : work[2*W-1:W];
      hiLo    = {hiReg, loReg};
      case (opReg)
         OP_MADD:         result = hiLo + product;
         OP_MSUB:         result = hiLo - product;
         OP_DIV, OP_DIVU: result = dz ? work : {rem, quo};
         default:         result = product;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.Start && !startIsMove) nextState = divZero ? FINAL : RUN;
         RUN:     if (count == CW'(W-1)) nextState = FINAL;
         FINAL:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         opReg   <= OP_MULT;
         count   <= '0;
         work    <= '0;
         operand <= '0;
         negLo   <= 1'b0;
         negHi   <= 1'b0;
         dz      <= 1'b0;
         hiReg   <= '0;
         loReg   <= '0;
         doneReg <= 1'b0;
         dzReg   <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         dzReg   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  if (opIn == OP_MTHI) begin
                     hiReg   <= bus.OperandA;
                     doneReg <= 1'b1;
                  end else if (opIn == OP_MTLO) begin
                     loReg   <= bus.OperandA;
                     doneReg <= 1'b1;
                  end else begin
                     opReg <= opIn;
                     count <= '0;
                     negLo <= aNeg ^ bNeg;
                     negHi <= aNeg;
                     dz    <= divZero;
                     if (divZero) begin
                        work <= {bus.OperandA, {W{1'b1}}};
                     end else if (startIsDiv) begin
                        work    <= {{W{1'b0}}, aAbs};
                        operand <= bAbs;
                     end else begin
                        work    <= {{W{1'b0}}, bAbs};
                        operand <= aAbs;
                     end
                  end
               end
            end
            RUN: begin
               count <= count + 1'b1;
               work  <= isDiv ? divStep : mulStep;
            end
            FINAL: begin
               {hiReg, loReg} <= result;
               doneReg        <= 1'b1;
               dzReg          <= dz;
            end
            default: ;
         endcase
      end
   end

   assign bus.Busy      = (state != IDLE);
   assign bus.Stall     = bus.Busy;
   assign bus.Done      = doneReg;
   assign bus.DivByZero = dzReg;
   assign bus.HiData    = hiReg;
   assign bus.LoData    = loReg;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO/DivByZero queued at issue, checked on Done.
module tb_hilo_muldiv_unit;
   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] hiM = '0;
   logic [31:0] loM = '0;
   logic [64:0] sb[$];
   logic [64:0] popped;

   hilo_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

   hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
      logic signed [63:0] sa, sb64, sq, sr;
      logic [63:0] p;
      sa   = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      case (op)
         3'd0: p = sa * sb64;
         3'd1: p = {32'b0, a} * {32'b0, b};
         3'd2, 3'd3: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            if (op == 3'd2) begin
               sq = sa / sb64;
               sr = sa % sb64;
               p  = {sr[31:0], sq[31:0]};
            end else begin
               p = {a % b, a / b};
            end
         end
         3'd4: p = {hi, lo} + 64'(sa * sb64);
         3'd5: p = {hi, lo} - 64'(sa * sb64);
         3'd6: p = {a, lo};
         default: p = {hi, a};
      endcase
      return {1'b0, p};
   endfunction

   always @(negedge Clk) begin
      if (bus.Done) begin
         if (sb.size() == 0) begin
            checkVal("spuriousDone", 64'd1, 64'd0);
         end else begin
            popped = sb.pop_front();
            checkVal("hi", 64'(bus.HiData), 64'(popped[63:32]));
            checkVal("lo", 64'(bus.LoData), 64'(popped[31:0]));
            checkVal("dz", 64'(bus.DivByZero), 64'(popped[64]));
         end
      end
      if (bus.DivByZero && !bus.Done) checkVal("dzWithoutDone", 64'd1, 64'd0);
   end

   task automatic pulseReset();
      @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      hiM = '0;
      loM = '0;
   endtask

   // injectAt/resetAt count negedges after the accepting edge; -1 disables them.
   task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo, input logic eDz,
                       input int expBusy, input int expLat, input int injectAt, input int resetAt);
      int  k;
      int  busyCnt;
      bit  seen;
      @(negedge Clk);
      bus.Start    = 1'b1;
      bus.Op       = op;
      bus.OperandA = a;
      bus.OperandB = b;
      if (resetAt < 0) sb.push_back({eDz, eHi, eLo});
      @(posedge Clk);
      @(negedge Clk);
      bus.Start = 1'b0;
      k = 1;
      busyCnt = 0;
      seen = 0;
      while (!seen && k <= 100) begin
         if (k == resetAt) begin
            Rst = 1'b0;
            #1;
            sb.delete();
            checkVal("rstBusy", 64'(bus.Busy), 64'd0);
            checkVal("rstHi", 64'(bus.HiData), 64'd0);
            checkVal("rstLo", 64'(bus.LoData), 64'd0);
            @(negedge Clk);
            Rst = 1'b1;
            hiM = '0;
            loM = '0;
            repeat (40) @(negedge Clk);
            checkVal("postRstBusy", 64'(bus.Busy), 64'd0);
            checkVal("postRstLo", 64'(bus.LoData), 64'd0);
            return;
         end
         if (injectAt > 0 && k == injectAt + 1) bus.Start = 1'b0;
         if (k == injectAt) begin
            bus.Start    = 1'b1;
            bus.Op       = 3'b010;
            bus.OperandA = 32'd1000;
            bus.OperandB = 32'd3;
         end
         if (k == 1) checkVal("stall", 64'(bus.Stall), 64'(bus.Busy));
         if (k == 10 && expBusy > 10) begin
            checkVal("hiStable", 64'(bus.HiData), 64'(hiM));
            checkVal("loStable", 64'(bus.LoData), 64'(loM));
         end
         if (bus.Busy) busyCnt++;
         if (bus.Done) seen = 1;
         else begin
            @(negedge Clk);
            k++;
         end
      end
      if (!seen) checkVal("timeout", 64'd0, 64'd1);
      checkVal("latency", 64'(k), 64'(expLat));
      checkVal("busyCycles", 64'(busyCnt), 64'(expBusy));
      hiM = eHi;
      loM = eLo;
      @(negedge Clk);
      checkVal("donePulse", 64'(bus.Done), 64'd0);
   endtask

   task automatic doModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int injectAt, input int resetAt);
      logic [64:0] e;
      bit isDz;
      e = refModel(op, a, b, hiM, loM);
      isDz = (op == 3'd2 || op == 3'd3) && b == 0;
      doOp(op, a, b, e[63:32], e[31:0], e[64], isDz ? 1 : 33, isDz ? 2 : 34, injectAt, resetAt);
   endtask

   initial begin
      bus.Start    = 1'b0;
      bus.Op       = '0;
      bus.OperandA = '0;
      bus.OperandB = '0;
      repeat (3) @(negedge Clk);
      checkVal("resetBusy", 64'(bus.Busy), 64'd0);
      checkVal("resetDone", 64'(bus.Done), 64'd0);
      checkVal("resetHi", 64'(bus.HiData), 64'd0);
      checkVal("resetLo", 64'(bus.LoData), 64'd0);
      Rst = 1'b1;

      doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 34, -1, -1);
      doOp(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 34, -1, -1);
      doOp(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 34, -1, -1);
      doOp(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 34, -1, -1);
      doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 34, -1, -1);

      pulseReset();
      doOp(3'd6, 32'd5, 32'd0, 32'd5, 32'd0, 1'b0, 0, 1, -1, -1);
      doOp(3'd4, 32'd2, 32'd3, 32'd5, 32'd6, 1'b0, 33, 34, -1, -1);
      doOp(3'd5, 32'd1, 32'd7, 32'd4, 32'hFFFF_FFFF, 1'b0, 33, 34, -1, -1);
      doOp(3'd7, 32'h1234, 32'd0, 32'd4, 32'h1234, 1'b0, 0, 1, -1, -1);

      doOp(3'd3, 32'hABCD, 32'd0, 32'hABCD, 32'hFFFF_FFFF, 1'b1, 1, 2, -1, -1);
      doOp(3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1, 2, -1, -1);

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 5));
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i % 2 == 1) b = -b;
         doModel(op, a, b, -1, -1);
      end

      doModel(3'd0, 32'h0001_2345, 32'hFFFF_FF00, 5, -1);
      doModel(3'd0, 32'h0BAD_CAFE, 32'h1234_5678, -1, 10);
      doModel(3'd1, 32'h0000_FFFF, 32'h0001_0001, -1, -1);

      repeat (3) @(negedge Clk);
      checkVal("sbDrained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
